// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the PC, reads words over a req/ack handshake and
// presents them to control until a halt is accepted. Define FETCH_COUNT_EN for a saturating accept counter.
module fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  localparam int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   halted,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]            fetch_count
`endif
);

  typedef enum logic [1:0] {START, FETCH, ISSUE, HALT} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
  logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
  logic                   accept;

  assign accept = (state_reg == ISSUE) && instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= START;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    case (state_reg)
      START: state_next = FETCH;
      FETCH: begin
        if (mem_ack) begin
          instr_next = mem_rdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Halt outranks redirect and leaves the PC pointing at the halt word.
        if (accept) begin
          if (halted) begin
            state_next = HALT;
          end else begin
            state_next = FETCH;
            pc_next    = redirect ? redirect_pc : pc_reg + PC_STEP;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = START;
    endcase
  end

  assign mem_req     = (state_reg == FETCH);
  assign instr_valid = (state_reg == ISSUE);
  assign mem_addr    = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;

`ifdef FETCH_COUNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (accept && (count_reg != 32'hFFFF_FFFF)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign fetch_count = count_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed transaction table, randomized
// transactions against a PC/instruction model, async reset and PC wrap sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_ack, instr_ready, halted, redirect;
  logic [15:0] mem_rdata, redirect_pc;

  logic        mem_req, instr_valid;
  logic [15:0] mem_addr, instr, pc;
  logic        b_mem_req, b_instr_valid;
  logic [15:0] b_mem_addr, b_instr, b_pc;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count, b_fetch_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(b_instr), .instr_valid(b_instr_valid),
    .instr_ready(instr_ready), .halted(halted), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(b_pc)
`ifdef FETCH_COUNT_EN
    , .fetch_count(b_fetch_count)
`endif
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] rdata;
    int          ack_wait;
    int          ready_wait;
    logic        redir;
    logic [15:0] rpc;
    logic        halt;
    logic        pulse;
    logic [15:0] next_pc;
  } txn_t;

  txn_t tbl[7];

  function automatic txn_t mk(input logic [15:0] p, input logic [15:0] d, input int aw,
                              input int rw, input logic rd, input logic [15:0] rp,
                              input logic h, input logic pu, input logic [15:0] np);
    txn_t t;
    t.pc = p; t.rdata = d; t.ack_wait = aw; t.ready_wait = rw; t.redir = rd;
    t.rpc = rp; t.halt = h; t.pulse = pu; t.next_pc = np;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one tick after an edge with the DUT expected in its fetch cycle.
  task automatic do_txn(input int idx, input txn_t t);
    chk("fetch_req", 32'(mem_req), 32'd1);
    chk("fetch_addr", 32'(mem_addr), 32'(t.pc));
    for (int w = 0; w < t.ack_wait; w++) begin
      if (t.pulse) begin
        redirect = 1'b1; halted = 1'b1; redirect_pc = 16'hDEAD;
      end
      step();
      redirect = 1'b0; halted = 1'b0;
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_addr", 32'(mem_addr), 32'(t.pc));
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = t.rdata;
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("issue_valid", 32'(instr_valid), 32'd1);
    chk("issue_instr", 32'(instr), 32'(t.rdata));
    chk("issue_noreq", 32'(mem_req), 32'd0);
    for (int w = 0; w < t.ready_wait; w++) begin
      instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = ~t.rdata;
      step();
      mem_ack = 1'b0;
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", 32'(instr), 32'(t.rdata));
    end
    instr_ready = 1'b1; redirect = t.redir; redirect_pc = t.rpc; halted = t.halt;
    step();
    instr_ready = 1'b0; redirect = 1'b0; halted = 1'b0; redirect_pc = 16'h0000;
    if (t.halt) begin
      chk("halt_req", 32'(mem_req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_pc", 32'(pc), 32'(t.pc));
    end else begin
      chk("next_req", 32'(mem_req), 32'd1);
      chk("next_addr", 32'(mem_addr), 32'(t.next_pc));
    end
    $display("txn %0d pc=%04h instr=%04h redir=%0b halt=%0b next=%04h",
             idx, t.pc, t.rdata, t.redir, t.halt, t.next_pc);
  endtask

  initial begin
    logic [15:0] exp_pc;
    int          accepts;
    txn_t        t;

    reset_n = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; halted = 1'b0;
    redirect = 1'b0; mem_rdata = 16'h0000; redirect_pc = 16'h0000;

    tbl[0] = mk(16'h0000, 16'h1123, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001);
    tbl[1] = mk(16'h0001, 16'h1123, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002);
    tbl[2] = mk(16'h0002, 16'h1123, 3, 2, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003);
    tbl[3] = mk(16'h0003, 16'h3AA5, 0, 0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0005);
    tbl[4] = mk(16'h0005, 16'h4001, 1, 1, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0040);
    tbl[5] = mk(16'h0040, 16'h5555, 2, 0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0041);
    tbl[6] = mk(16'h0041, 16'hF000, 0, 3, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0041);

    step();
    step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_addr", 32'(mem_addr), 32'h0000);
    chk("rst_instr", 32'(instr), 32'h0000);
    reset_n = 1'b1;
    chk("start_req", 32'(mem_req), 32'd0);
    step();

    for (int i = 0; i < 7; i++) do_txn(i, tbl[i]);

    for (int c = 0; c < 22; c++) begin
      mem_ack = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0777;
      step();
      chk("halt_hold_req", 32'(mem_req), 32'd0);
      chk("halt_hold_pc", 32'(pc), 32'h0041);
    end
    mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
`ifdef FETCH_COUNT_EN
    chk("count_halt", fetch_count, 32'd7);
`endif

    #2 reset_n = 1'b0;
    #1;
    chk("areset_pc", 32'(pc), 32'h0000);
    chk("areset_instr", 32'(instr), 32'h0000);
    step();
    reset_n = 1'b1;
    step();
    chk("restart_req", 32'(mem_req), 32'd1);
    chk("restart_addr", 32'(mem_addr), 32'h0000);

    // Model: an accepted word goes to redirect_pc when redirected, else to pc+1 mod 2^16.
    exp_pc = 16'h0000;
    accepts = 0;
    for (int i = 0; i < 200; i++) begin
      t.pc = exp_pc;
      t.rdata = 16'($urandom);
      t.ack_wait = int'($urandom_range(0, 3));
      t.ready_wait = int'($urandom_range(0, 2));
      t.redir = ($urandom_range(0, 3) == 0);
      t.rpc = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      t.halt = 1'b0;
      t.pulse = 1'($urandom_range(0, 1));
      t.next_pc = t.redir ? t.rpc : 16'((32'(exp_pc) + 1) % 65536);
      do_txn(100 + i, t);
      exp_pc = t.next_pc;
      accepts++;
    end
`ifdef FETCH_COUNT_EN
    chk("count_random", fetch_count, 32'(accepts));
`endif

    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    chk("pre_rst_instr", 32'(instr), 32'hBEEF);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'h0000);
    chk("mid_rst_instr", 32'(instr), 32'h0000);

    step();
    reset_n = 1'b1;
    step();
    chk("wrap_req", 32'(b_mem_req), 32'd1);
    chk("wrap_addr0", 32'(b_mem_addr), 32'hFFFF);
    mem_ack = 1'b1; mem_rdata = 16'h1ABC;
    step();
    mem_ack = 1'b0;
    chk("wrap_instr", 32'(b_instr), 32'h1ABC);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("wrap_next_req", 32'(b_mem_req), 32'd1);
    chk("wrap_next_addr", 32'(b_mem_addr), 32'h0000);
    $display("txn wrap pc=ffff instr=1abc next=%04h", b_mem_addr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the little computer: walks the program counter, reads instruction words from instruction memory over a request/acknowledge handshake, and presents each word to the `control` decoder and datapath. It is the producer of the `instr` word that `control` consumes. It stops fetching permanently once `control` flags the presented instruction as a halt.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: instruction-memory word-address width; also the PC width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  ADDR_WIDTH  word address of the request.
- `mem_ack`  in  1  read complete; `mem_rdata` valid this cycle.
- `mem_rdata`  in  `InstrWidth` (16)  instruction word from memory.
- `instr`  out  `InstrWidth`  instruction presented to `control`.
- `instr_valid`  out  1  `instr` holds a fetched word.
- `instr_ready`  in  1  consumer accepts `instr` this cycle.
- `halted`  in  1  from `control`, decoded from the current `instr`.
- `redirect`  in  1  next PC comes from `redirect_pc` (branch/jump).
- `redirect_pc`  in  ADDR_WIDTH  redirect target.
- `pc`  out  ADDR_WIDTH  address of the word in `instr`/being fetched.

## Operation
- States: START, FETCH, ISSUE, HALT. `mem_req` = (state==FETCH); `instr_valid` = (state==ISSUE); both decode directly from the state register.
- START: unconditional -> FETCH next cycle.
- FETCH: `mem_addr` = `pc`, held stable until `mem_ack`. On `mem_ack`: `instr` <= `mem_rdata`, -> ISSUE.
- ISSUE: `instr` held stable while `instr_ready`=0. Accept = `instr_valid` & `instr_ready`. On accept:
  - `halted`=1 -> HALT; `pc` unchanged.
  - else `redirect`=1 -> `pc` <= `redirect_pc`, -> FETCH.
  - else `pc` <= `pc`+1, -> FETCH.
- HALT: terminal; `mem_req`=0, `instr_valid`=0, `pc` frozen; only `reset_n` leaves.
- `halted` and `redirect` are sampled only on the accept cycle; ignored otherwise.
- `mem_ack` outside FETCH is ignored.
- PC arithmetic: ADDR_WIDTH bits, increment wraps 2^ADDR_WIDTH-1 -> 0.
- Simultaneous `halted` and `redirect` on accept: halt wins, no PC update.

## Timing
- Reset values: state=START, `mem_req`=0, `mem_addr`=`pc`=RESET_PC, `instr`=0, `instr_valid`=0.
- First cycle after `reset_n` rises: START; second: `mem_req`=1.
- `mem_ack` in cycle N -> `instr_valid`=1 in cycle N+1.
- Accept in cycle M -> `mem_req`=1 with new `mem_addr` in M+1 (or HALT).
- Zero-wait memory and `instr_ready` held high: one instruction every 2 cycles.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously); an outstanding memory read is abandoned, memory must tolerate a dropped `mem_req`.

## Configuration
- `FETCH_COUNT_EN` defined: adds output `fetch_count` (32 bits), reset 0, +1 on every accept (halt instruction included), saturates at 0xFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: `reset_n`=0 -> `mem_req`=0, `instr_valid`=0, `pc`=0x0000; release -> `mem_req`=1, `mem_addr`=0x0000 on the 2nd cycle.
- Streaming: zero-wait memory returns {`OP_ADD`,12'h123} at 0,1,2, `instr_ready`=1 -> `mem_addr` 0,1,2 on alternate cycles, `instr`=0x?123 valid each in between.
- Backpressure: `mem_ack` 3 cycles late, then `instr_ready`=0 for 2 cycles -> `mem_addr` stable during wait, `instr` stable while not ready, single accept.
- Redirect: accept at `pc`=0x0005 with `redirect`=1, `redirect_pc`=0x0040 -> next `mem_addr`=0x0040; `redirect` pulsed in FETCH -> ignored.
- Halt: {`OP_HALT`,12'b0} with `halted`=1 and `redirect`=1 on accept -> HALT, `mem_req`=0 for 20+ cycles, `pc` unchanged; with `FETCH_COUNT_EN`, `fetch_count` includes the halt; `reset_n` pulse -> fetch restarts at RESET_PC.
- Wrap: RESET_PC=0xFFFF, accept without redirect -> next `mem_addr`=0x0000.
